// File: rtl/expr_vector_sequencer_if.sv
// Harness/datapath-facing bundle of expr_vector_sequencer: run control,
// operand vector out, datapath result in, signature and status back.
interface expr_vector_sequencer_if #(
    parameter int unsigned IN_W  = 60,
    parameter int unsigned OUT_W = 90,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [63:0]      seed;
    logic [CNT_W-1:0] num_vec;
    logic [IN_W-1:0]  op_vec;
    logic [OUT_W-1:0] y;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] sig;
    logic [CNT_W-1:0] vec_cnt;

    modport master (
        output start, abort, seed, num_vec, y,
        input  op_vec, busy, done, sig, vec_cnt
    );

    modport slave (
        input  start, abort, seed, num_vec, y,
        output op_vec, busy, done, sig, vec_cnt
    );
endinterface

// File: rtl/expr_vector_sequencer.sv
// Drives LFSR operand vectors into a combinational expression, waits a settle
// time per vector and folds each result into a rotate-XOR signature.
module expr_vector_sequencer #(
    parameter int unsigned IN_W   = 60,
    parameter int unsigned OUT_W  = 90,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 16
) (
    input logic                    clk,
    input logic                    rst,
    expr_vector_sequencer_if.slave bus
);
    localparam int unsigned LFSR_W = 64;
    localparam int unsigned SET_W  = 4;
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next_c;
    logic [CNT_W-1:0]  num_lat;
    logic [SET_W-1:0]  settle_cnt;
    logic              abort_c;
    logic              last_c;

    assign lfsr_next_c = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
    assign abort_c     = bus.abort && (state != S_IDLE);
    assign last_c      = (CNT_W'(bus.vec_cnt + 1'b1) == num_lat);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (bus.start) state_next = S_LOAD;
            S_LOAD:    state_next = (num_lat == '0) ? S_DONE : S_DRIVE;
            S_DRIVE:   state_next = (SETTLE_INIT == '0) ? S_CAPTURE : S_WAIT;
            S_WAIT:    if (settle_cnt == SET_W'(1)) state_next = S_CAPTURE;
            S_CAPTURE: state_next = last_c ? S_DONE : S_DRIVE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (abort_c) begin
            state_next = S_IDLE;
        end
    end

    // Datapath and registered status; seed and count are taken on the accept cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr        <= LFSR_W'(1);
            num_lat     <= '0;
            settle_cnt  <= '0;
            bus.op_vec  <= '0;
            bus.sig     <= '0;
            bus.vec_cnt <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.busy <= (state_next != S_IDLE);
            bus.done <= (state_next == S_DONE);
            if (!abort_c) begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            lfsr    <= (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
                            num_lat <= bus.num_vec;
                        end
                    end
                    S_LOAD: begin
                        bus.sig     <= '0;
                        bus.vec_cnt <= '0;
                    end
                    S_DRIVE: begin
                        bus.op_vec <= lfsr[IN_W-1:0];
                        settle_cnt <= SETTLE_INIT;
                    end
                    S_WAIT: begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                    S_CAPTURE: begin
                        bus.sig     <= {bus.sig[OUT_W-2:0], bus.sig[OUT_W-1]} ^ bus.y;
                        bus.vec_cnt <= bus.vec_cnt + CNT_W'(1);
                        lfsr        <= lfsr_next_c;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Directed bench for expr_vector_sequencer with SETTLE=1 and a small
// selectable expression model standing in for the datapath.
module tb_expr_vector_sequencer;
    localparam int unsigned IN_W  = 60;
    localparam int unsigned OUT_W = 90;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    int   mode;
    int   checks = 0;
    int   errors = 0;

    logic [OUT_W-1:0] sig_log[$];
    logic [IN_W-1:0]  op_log[$];

    always #5 clk = ~clk;

    expr_vector_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    // Datapath stand-ins: constant 1, zero-extended operands, or an XOR mix
    always_comb begin
        case (mode)
            0:       bus.y = OUT_W'(1);
            1:       bus.y = OUT_W'(bus.op_vec);
            default: bus.y = {bus.op_vec[59:30] ^ bus.op_vec[29:0], bus.op_vec};
        endcase
    end

    expr_vector_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Runs from the current negedge until done; cyc=-1 when the budget expires
    task automatic run_to_done(input int budget, input bit hold, output int cyc);
        logic [CNT_W-1:0] prev;
        prev = bus.vec_cnt;
        sig_log.delete();
        op_log.delete();
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            if (!hold) bus.start = 1'b0;
            if (bus.vec_cnt == CNT_W'(prev + 1'b1)) begin
                sig_log.push_back(bus.sig);
                op_log.push_back(bus.op_vec);
            end
            prev = bus.vec_cnt;
            if (bus.done) return;
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.seed = '0; bus.num_vec = '0;
        mode = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0h exp 0", bus.done); end
        checks++; if (bus.sig !== '0) begin errors++; $display("FAIL reset_sig got %0h exp 0", bus.sig); end
        checks++; if (bus.vec_cnt !== '0) begin errors++; $display("FAIL reset_vec_cnt got %0h exp 0", bus.vec_cnt); end
        checks++; if (bus.op_vec !== '0) begin errors++; $display("FAIL reset_op_vec got %0h exp 0", bus.op_vec); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        logic [OUT_W-1:0] es [3];
        es = '{OUT_W'(1), OUT_W'(3), OUT_W'(7)};
        mode = 0;
        bus.seed = 64'h1; bus.num_vec = 16'd3; bus.start = 1'b1;
        @(negedge clk);
        // late changes must not disturb the run already accepted
        bus.start = 1'b0; bus.num_vec = 16'd9; bus.seed = 64'hDEAD;
        run_to_done(100, 1'b0, cyc);
        checks++; if (cyc + 1 !== 11) begin errors++; $display("FAIL basic_latency got %0d exp 11", cyc + 1); end
        checks++; if (sig_log.size() !== 3) begin errors++; $display("FAIL basic_nlog got %0d exp 3", sig_log.size()); end
        else for (int k = 0; k < 3; k++) begin
            checks++; if (sig_log[k] !== es[k]) begin errors++; $display("FAIL basic_sig[%0d] got %0h exp %0h", k, sig_log[k], es[k]); end
        end
        checks++; if (bus.vec_cnt !== 16'd3) begin errors++; $display("FAIL basic_vec_cnt got %0d exp 3", bus.vec_cnt); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_in_done got %0h exp 1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0h exp 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %0h exp 0", bus.busy); end
        checks++; if (bus.sig !== OUT_W'(7)) begin errors++; $display("FAIL basic_sig_hold got %0h exp 7", bus.sig); end
    endtask

    task automatic test_zero_vec();
        int cyc;
        bus.seed = 64'h1234; bus.num_vec = '0; bus.start = 1'b1;
        run_to_done(20, 1'b0, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL zero_latency got %0d exp 2", cyc); end
        checks++; if (bus.sig !== '0) begin errors++; $display("FAIL zero_sig got %0h exp 0", bus.sig); end
        checks++; if (bus.op_vec !== IN_W'(4)) begin errors++; $display("FAIL zero_op_hold got %0h exp 4", bus.op_vec); end
        checks++; if (sig_log.size() !== 0) begin errors++; $display("FAIL zero_captures got %0d exp 0", sig_log.size()); end
        @(negedge clk);
    endtask

    task automatic test_seed_zero();
        int cyc;
        logic [IN_W-1:0]  eo [4];
        logic [OUT_W-1:0] es [4];
        eo = '{IN_W'(1), IN_W'(2), IN_W'(4), IN_W'(8)};
        es = '{OUT_W'(1), OUT_W'(0), OUT_W'(4), OUT_W'(0)};
        mode = 1;
        for (int s = 0; s < 2; s++) begin
            bus.seed = 64'(s); bus.num_vec = 16'd4; bus.start = 1'b1;
            run_to_done(100, 1'b0, cyc);
            checks++; if (cyc !== 14) begin errors++; $display("FAIL seed%0d_latency got %0d exp 14", s, cyc); end
            checks++; if (op_log.size() !== 4) begin errors++; $display("FAIL seed%0d_nlog got %0d exp 4", s, op_log.size()); end
            else for (int k = 0; k < 4; k++) begin
                checks++; if (op_log[k] !== eo[k] || sig_log[k] !== es[k]) begin
                    errors++; $display("FAIL seed%0d_vec[%0d] got op %0h sig %0h exp op %0h sig %0h", s, k, op_log[k], sig_log[k], eo[k], es[k]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_feedback();
        int cyc;
        // bit 59 feeds back into bit 0; bit 60 falls off the operand bus
        mode = 1;
        bus.seed = 64'h0800_0000_0000_0000; bus.num_vec = 16'd2; bus.start = 1'b1;
        run_to_done(100, 1'b0, cyc);
        checks++; if (op_log.size() !== 2) begin errors++; $display("FAIL fb_nlog got %0d exp 2", op_log.size()); end
        else begin
            checks++; if (op_log[0] !== 60'h800_0000_0000_0000) begin errors++; $display("FAIL fb_op0 got %0h exp 800000000000000", op_log[0]); end
            checks++; if (op_log[1] !== 60'h1) begin errors++; $display("FAIL fb_op1 got %0h exp 1", op_log[1]); end
        end
        checks++; if (bus.sig !== 90'h1000_0000_0000_0001) begin errors++; $display("FAIL fb_sig got %0h exp 1000000000000001", bus.sig); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int cyc;
        int pulses;
        mode = 0;
        bus.seed = 64'h1; bus.num_vec = 16'd5; bus.start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++; if (bus.vec_cnt !== 16'd1) begin errors++; $display("FAIL abort_pre_cnt got %0d exp 1", bus.vec_cnt); end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0h exp 0", bus.busy); end
        pulses = int'(bus.done);
        repeat (10) begin @(negedge clk); pulses += int'(bus.done); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_done_pulses got %0d exp 0", pulses); end
        bus.num_vec = 16'd2; bus.start = 1'b1;
        run_to_done(100, 1'b0, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL abort_rerun_latency got %0d exp 8", cyc); end
        checks++; if (bus.sig !== OUT_W'(3)) begin errors++; $display("FAIL abort_rerun_sig got %0h exp 3", bus.sig); end
        checks++; if (bus.vec_cnt !== 16'd2) begin errors++; $display("FAIL abort_rerun_cnt got %0d exp 2", bus.vec_cnt); end
        @(negedge clk);
    endtask

    task automatic test_start_held();
        int first, second, pulses;
        logic busy6;
        mode = 0;
        first = 0; second = 0; pulses = 0; busy6 = 1'bx;
        bus.seed = 64'h1; bus.num_vec = 16'd1; bus.start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (first == 0) first = i; else second = i;
            end
            if (i == 6) busy6 = bus.busy;
            if (i == 12) bus.start = 1'b0;
        end
        @(negedge clk);
        checks++; if (pulses !== 2) begin errors++; $display("FAIL held_pulses got %0d exp 2", pulses); end
        checks++; if (first !== 5 || second !== 11) begin errors++; $display("FAIL held_done_cycles got %0d,%0d exp 5,11", first, second); end
        checks++; if (busy6 !== 1'b0) begin errors++; $display("FAIL held_idle_gap got %0h exp 0", busy6); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_no_third_run got %0h exp 0", bus.busy); end
    endtask

    task automatic test_reset_midrun();
        mode = 0;
        bus.seed = 64'h1; bus.num_vec = 16'd5; bus.start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL rstmid_busy_done got %0b exp 00", {bus.busy, bus.done}); end
        checks++; if (bus.sig !== '0) begin errors++; $display("FAIL rstmid_sig got %0h exp 0", bus.sig); end
        checks++; if (bus.vec_cnt !== '0) begin errors++; $display("FAIL rstmid_cnt got %0h exp 0", bus.vec_cnt); end
        checks++; if (bus.op_vec !== '0) begin errors++; $display("FAIL rstmid_op got %0h exp 0", bus.op_vec); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle got %0h exp 0", bus.busy); end
    endtask

    task automatic test_random();
        int cyc;
        int bad;
        logic [63:0]      l;
        logic [OUT_W-1:0] s;
        logic [IN_W-1:0]  op;
        logic [IN_W-1:0]  exp_op[$];
        mode = 2;
        bus.seed = {$urandom(), $urandom()};
        l = (bus.seed == '0) ? 64'h1 : bus.seed;
        s = '0;
        for (int k = 0; k < 256; k++) begin
            op = l[IN_W-1:0];
            exp_op.push_back(op);
            s = {s[OUT_W-2:0], s[OUT_W-1]} ^ {op[59:30] ^ op[29:0], op};
            l = {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
        end
        bus.num_vec = 16'd256; bus.start = 1'b1;
        run_to_done(2000, 1'b0, cyc);
        checks++; if (cyc !== 770) begin errors++; $display("FAIL rand_latency got %0d exp 770", cyc); end
        checks++; if (bus.vec_cnt !== 16'd256) begin errors++; $display("FAIL rand_cnt got %0d exp 256", bus.vec_cnt); end
        checks++; if (bus.sig !== s) begin errors++; $display("FAIL rand_sig got %0h exp %0h", bus.sig, s); end
        bad = (op_log.size() == 256) ? 0 : 1;
        for (int k = 0; k < op_log.size() && k < 256; k++) begin
            if (op_log[k] !== exp_op[k]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rand_op_seq got %0d bad entries exp 0", bad); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_vec();
        test_seed_zero();
        test_feedback();
        test_abort();
        test_start_held();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1);
    end
endmodule
